// File: rtl/mult_div_unit_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMult = 2'd1,
        StDiv  = 2'd2,
        StFix  = 2'd3
    } mdu_state_t;

    localparam int unsigned MDU_DIV_STEPS = 32;
    localparam int unsigned MDU_CNT_W     = 5;

    // Magnitude as an unsigned value; 0x80000000 maps to itself, which is exact.
    function automatic logic [31:0] mdu_abs(input logic [31:0] val, input logic is_signed);
        return (is_signed && val[31]) ? (~val + 32'd1) : val;
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Unsigned 32-step restoring divider core; one quotient bit per i_step.
module mdu_divider
    import mult_div_unit_pkg::*;
(
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;
    logic [32:0] w_shifted;
    logic [33:0] w_diff;

    // Shifted partial remainder can reach 33 bits when the divisor is above 2^31.
    assign w_shifted = {r_rem, r_quo[31]};
    assign w_diff    = {1'b0, w_shifted} - {2'b00, r_dvs};

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
        end else if (i_load) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_dvs <= i_divisor;
        end else if (i_step) begin
            if (!w_diff[33]) begin
                r_rem <= w_diff[31:0];
                r_quo <= {r_quo[30:0], 1'b1};
            end else begin
                r_rem <= w_shifted[31:0];
                r_quo <= {r_quo[30:0], 1'b0};
            end
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: sequencing FSM, multiplier, sign fix-up
// and the architectural HI/LO registers.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_operandA,
    input  logic [31:0] i_operandB,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam logic [MDU_CNT_W-1:0] MULT_CNT_INIT = MDU_CNT_W'(MULT_CYCLES - 1);
    localparam logic [MDU_CNT_W-1:0] DIV_CNT_INIT  = MDU_CNT_W'(MDU_DIV_STEPS - 1);

    mdu_state_t           r_state, w_state_next;
    logic [MDU_CNT_W-1:0] r_cnt, w_cnt_next;
    logic [31:0]          r_hi, w_hi_next;
    logic [31:0]          r_lo, w_lo_next;
    logic                 r_done, w_done_next;
    logic [31:0]          r_op_a, r_op_b;
    logic                 r_signed, r_q_neg, r_r_neg, r_div_zero;

    mdu_op_t     w_op;
    logic        w_op_signed;
    logic        w_latch;
    logic        w_div_load;
    logic        w_div_step;
    logic [63:0] w_ext_a, w_ext_b, w_prod;
    logic [31:0] w_quo, w_rem;

    assign w_op        = mdu_op_t'(i_op);
    assign w_op_signed = (w_op == MDU_MULT) || (w_op == MDU_DIV);

    // Sign-extending both operands lets one 64-bit multiply serve MULT and MULTU.
    assign w_ext_a = {{32{r_signed & r_op_a[31]}}, r_op_a};
    assign w_ext_b = {{32{r_signed & r_op_b[31]}}, r_op_b};
    assign w_prod  = w_ext_a * w_ext_b;

    mdu_divider u_divider (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_load      (w_div_load),
        .i_step      (w_div_step),
        .i_dividend  (mdu_abs(i_operandA, w_op_signed)),
        .i_divisor   (mdu_abs(i_operandB, w_op_signed)),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        w_done_next  = 1'b0;
        w_latch      = 1'b0;
        w_div_load   = 1'b0;
        w_div_step   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start && !i_flush) begin
                    case (w_op)
                        MDU_MTHI: w_hi_next = i_operandA;
                        MDU_MTLO: w_lo_next = i_operandA;
                        MDU_MULT, MDU_MULTU: begin
                            w_latch      = 1'b1;
                            w_cnt_next   = MULT_CNT_INIT;
                            w_state_next = StMult;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            w_latch      = 1'b1;
                            w_div_load   = 1'b1;
                            w_cnt_next   = DIV_CNT_INIT;
                            w_state_next = StDiv;
                        end
                        default: ;
                    endcase
                end
            end
            StMult: begin
                if (i_flush) begin
                    w_cnt_next   = '0;
                    w_state_next = StIdle;
                end else if (r_cnt == '0) begin
                    w_hi_next    = w_prod[63:32];
                    w_lo_next    = w_prod[31:0];
                    w_done_next  = 1'b1;
                    w_state_next = StIdle;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            StDiv: begin
                if (i_flush) begin
                    w_cnt_next   = '0;
                    w_state_next = StIdle;
                end else begin
                    w_div_step = 1'b1;
                    if (r_cnt == '0) begin
                        w_state_next = StFix;
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end
            end
            StFix: begin
                w_state_next = StIdle;
                if (!i_flush) begin
                    w_done_next = 1'b1;
                    // Divide by zero bypasses sign fix-up: all-ones quotient, raw dividend.
                    if (r_div_zero) begin
                        w_lo_next = 32'hFFFF_FFFF;
                        w_hi_next = r_op_a;
                    end else begin
                        w_lo_next = r_q_neg ? (~w_quo + 32'd1) : w_quo;
                        w_hi_next = r_r_neg ? (~w_rem + 32'd1) : w_rem;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_done  <= w_done_next;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_signed   <= 1'b0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (w_latch) begin
            r_op_a     <= i_operandA;
            r_op_b     <= i_operandB;
            r_signed   <= w_op_signed;
            r_q_neg    <= w_op_signed && (i_operandA[31] ^ i_operandB[31]);
            r_r_neg    <= w_op_signed && i_operandA[31];
            r_div_zero <= (i_operandB == 32'd0);
        end
    end

    assign o_busy = (r_state != StIdle);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests;
    int n_fail;

    mult_div_unit #(
        .MULT_CYCLES (4)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_start    (start),
        .i_op       (op),
        .i_operandA (opa),
        .i_operandB (opb),
        .i_flush    (flush),
        .o_busy     (busy),
        .o_done     (done),
        .o_hi       (hi),
        .o_lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issue at a negedge, count busy cycles, then check results and the done pulse.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cycles,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cycles;
        int dcount;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        check_eq({tag, " busy cycles"}, cycles, exp_cycles);
        check_eq({tag, " hi"}, hi, exp_hi);
        check_eq({tag, " lo"}, lo, exp_lo);
        check_eq({tag, " done"}, {31'd0, done}, 32'd1);
        dcount = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check_eq({tag, " done once"}, dcount, 0);
    endtask

    initial begin
        int dcount;
        n_tests = 0;
        n_fail  = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = MDU_MTHI;
        opa   = '0;
        opb   = '0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset busy", {31'd0, busy}, 32'd0);
        check_eq("reset done", {31'd0, done}, 32'd0);
        check_eq("reset hi", hi, 32'd0);
        check_eq("reset lo", lo, 32'd0);

        run_op("mult -3*7", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 4, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4,
               32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult -2*-3", MDU_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 4, 32'd0, 32'd6);
        run_op("div -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div 7/-2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
        run_op("divu 100/7", MDU_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        run_op("divu big", MDU_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 33,
               32'h7FFF_FFFE, 32'd1);
        run_op("divu 5/0", MDU_DIVU, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF);
        run_op("div -5/0", MDU_DIV, 32'hFFFF_FFFB, 32'd0, 33, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("div min/-1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33,
               32'd0, 32'h8000_0000);

        // MTHI then MULT back-to-back; a start during busy must be dropped.
        @(negedge clk);
        start = 1'b1;
        op    = MDU_MTHI;
        opa   = 32'h0000_1234;
        @(negedge clk);
        check_eq("mthi hi", hi, 32'h0000_1234);
        check_eq("mthi busy", {31'd0, busy}, 32'd0);
        op  = MDU_MULT;
        opa = 32'd5;
        opb = 32'd6;
        @(negedge clk);
        check_eq("b2b busy", {31'd0, busy}, 32'd1);
        check_eq("b2b hi held", hi, 32'h0000_1234);
        op  = MDU_MTLO;
        opa = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0;
        dcount = 0;
        while (busy && dcount < 100) begin
            dcount++;
            @(negedge clk);
        end
        check_eq("ignored start hi", hi, 32'd0);
        check_eq("ignored start lo", lo, 32'd30);

        // Flush during the tenth DIV cycle.
        repeat (2) @(negedge clk);
        start = 1'b1;
        op    = MDU_DIVU;
        opa   = 32'd100;
        opb   = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("pre-flush busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush busy", {31'd0, busy}, 32'd0);
        check_eq("flush hi", hi, 32'd0);
        check_eq("flush lo", lo, 32'd30);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        check_eq("flush no done", dcount, 0);

        // Flush and start together in IDLE: MTHI must be ignored.
        start = 1'b1;
        flush = 1'b1;
        op    = MDU_MTHI;
        opa   = 32'h5555_AAAA;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check_eq("flush+start hi", hi, 32'd0);
        check_eq("flush+start busy", {31'd0, busy}, 32'd0);

        // Async reset mid-MULT, checked before the next rising edge.
        start = 1'b1;
        op    = MDU_MTHI;
        opa   = 32'h0000_00AB;
        @(negedge clk);
        op  = MDU_MULT;
        opa = 32'd3;
        opb = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check_eq("pre-reset busy", {31'd0, busy}, 32'd1);
        check_eq("pre-reset hi", hi, 32'h0000_00AB);
        #2 rst = 1'b1;
        #1;
        check_eq("async reset busy", {31'd0, busy}, 32'd0);
        check_eq("async reset done", {31'd0, done}, 32'd0);
        check_eq("async reset hi", hi, 32'd0);
        check_eq("async reset lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("post-reset busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle HI/LO multiply/divide unit used by the execution stage for MULT, MULTU, DIV, DIVU, MTHI and MTLO. The execution stage issues an operation with a one-cycle `start` pulse and stalls the pipeline while `busy` is high. HI/LO are architectural state held here. MFHI/MFLO read `hi`/`lo` directly, with no forwarding.

## Interface
- `MULT_CYCLES`, default 4: busy cycles for MULT/MULTU; legal range 1..16.
- `clock`  in  1: sole clock; all state changes on rising edge.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: issue strobe, sampled on the rising edge; ignored while `busy`.
- `op`  in  3: `mdu_op_t`: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
- `operandA`  in  32: rs value (dividend / multiplicand / MTHI/MTLO source).
- `operandB`  in  32: rt value (divisor / multiplier).
- `flush`  in  1: cancel an in-flight operation (branch squash / reset of younger instruction).
- `busy`  out  1: operation in flight; execution stage must stall any MDU instruction, MFHI or MFLO.
- `done`  out  1: one-cycle pulse, the cycle after HI/LO are updated by a mult/div.
- `hi`, `lo`  out  32 each: architectural HI/LO.

## Operation
- States: IDLE, MULT, DIV, FIX.
- IDLE:
  - `start` with MTHI: `hi <= operandA`, stay IDLE.
  - `start` with MTLO: `lo <= operandA`, stay IDLE.
  - `start` with MULT/MULTU: latch operands, counter `<= MULT_CYCLES-1`, go to MULT.
  - `start` with DIV/DIVU: latch operand magnitudes (signed) or raw values (unsigned), record quotient/remainder signs, counter `<= 31`, go to DIV.
- MULT:
  - Counter decrements each cycle; product is computed from the latched operands.
  - At counter 0: `{hi,lo} <=` 64-bit product (signed or unsigned per op), go to IDLE.
- DIV: one restoring-division step per cycle (32 steps); at counter 0 go to FIX.
- FIX: apply signs, write `lo` = quotient and `hi` = remainder, go to IDLE.
  - Quotient is negative iff operand signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero (any signedness): `lo = 32'hFFFFFFFF`, `hi = operandA` (original value). Same latency as a normal divide.
- DIV of 0x80000000 by 0xFFFFFFFF: `lo = 0x80000000`, `hi = 0`. Requires 33-bit magnitude handling; no trap.
- `flush` high while `busy`: return to IDLE next edge; `hi`/`lo` unchanged; no `done`.
- `flush` and `start` in the same IDLE cycle: `start` ignored (including MTHI/MTLO).
- `busy` = (state != IDLE).
- `done` is registered: high exactly the cycle after the final HI/LO write edge.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0, counter 0. Reset mid-operation aborts immediately, asynchronously.
- `start` sampled at edge E0.
- MULT/MULTU:
  - `busy` high for exactly `MULT_CYCLES` cycles after E0.
  - `hi`/`lo` take new values at the edge where `busy` falls.
  - `done` high the following cycle.
- DIV/DIVU:
  - `busy` high for 33 cycles (32 DIV + 1 FIX).
  - `hi`/`lo` update at the edge `busy` falls; `done` follows.
- MTHI/MTLO: value visible on `hi`/`lo` the cycle after E0; `busy` never asserts.
- `start` while `busy` (without `flush`) is dropped; upstream guarantees this does not happen.
- Back-to-back issue is allowed: `start` in the first cycle `busy` is low is accepted.

## Structure
- Shared package entries: `mdu_op_t` enum, `MDU_DIV_STEPS = 32`, `mdu_state_t` enum.
- Sub-module `mdu_divider`: unsigned 32-step restoring divider core, holding the quotient/remainder shift registers and exposing `step`/`load` controls.
- Sign fix-up, multiplier and HI/LO registers live in `mult_div_unit`.

## Test plan
- MULT -3 × 7 with `MULT_CYCLES=4`: `busy` high 4 cycles; then `hi=32'hFFFFFFFF`, `lo=32'hFFFFFFEB`; `done` pulses once.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: `hi=32'hFFFFFFFE`, `lo=32'h00000001`.
- DIV -7 / 2: `busy` 33 cycles; then `lo=32'hFFFFFFFD`, `hi=32'hFFFFFFFF`. DIVU 100 / 7: `lo=14`, `hi=2`.
- DIVU 5 / 0: `lo=32'hFFFFFFFF`, `hi=5`. DIV 0x80000000 / -1: `lo=0x80000000`, `hi=0`.
- MTHI 0x1234 followed immediately by MULT: `hi=0x1234` for one cycle, then busy. `start` during busy is ignored: final result is from the first op only.
- `flush` at DIV cycle 10: IDLE next cycle, `hi`/`lo` keep prior values, no `done`. Async `reset` mid-MULT: all outputs 0 without waiting for a clock edge.
